// File: rtl/ram.sv
// 32 x 32 single-port synchronous RAM with registered read data.
// Ports: clk, rst (sync, active-high), cen, wen, addr[4:0], din[31:0], dout[31:0].
module ram (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        wen,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam int DEPTH = 32;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_dout;

  logic w_wr;
  logic w_rd;

  assign w_wr = cen & wen;
  assign w_rd = cen & ~wen;

  // Storage is flop-based so a reset can clear every word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[addr] <= din;
    end
  end

  // Output is zero on any cycle that is not a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_rd) begin
      r_dout <= r_mem[addr];
    end else begin
      r_dout <= '0;
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram.
// Inputs change on the falling edge; dout is sampled on the next falling edge.
module tb_ram;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        wen;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  int n_chk;
  int n_fail;

  logic [31:0] xval;
  logic [5:0]  a6;

  ram u_ram (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .wen  (wen),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one access for one rising edge, return at the next falling edge.
  task automatic op(
    input logic        r,
    input logic        c,
    input logic        w,
    input logic [4:0]  a,
    input logic [31:0] d
  );
    rst  = r;
    cen  = c;
    wen  = w;
    addr = a;
    din  = d;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    op(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    op(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    xval   = 32'bx;
    rst  = 1'b1;
    cen  = 1'b1;
    wen  = 1'b1;
    addr = 5'd3;
    din  = 32'hFFFF_FFFF;

    // Reset overrides a write in the same cycle.
    @(negedge clk);
    chk("rst_dout", dout, 32'h0);
    rd(5'd3);
    chk("rst_rd3", dout, 32'h0);

    // Sequential writes, skipping word 10.
    for (int k = 0; k <= 18; k++) begin
      if (k != 10) begin
        wr(5'(k), 32'(k));
        if (k == 4) chk("wr_dout0", dout, 32'h0);
      end
    end
    for (int k = 0; k <= 18; k++) begin
      rd(5'(k));
      chk($sformatf("seq_rd%0d", k), dout, (k == 10) ? 32'h0 : 32'(k));
    end

    // X data is stored and returned unchanged.
    wr(5'd9, xval);
    rd(5'd9);
    chk("x_rd9", dout, xval);
    rd(5'd8);
    chk("x_rd8", dout, 32'd8);
    rd(5'd11);
    chk("x_rd11", dout, 32'd11);

    // A 6-bit address of 33 selects word 1.
    a6 = 6'd33;
    wr(a6[4:0], 32'd33);
    rd(5'd1);
    chk("trunc_rd1", dout, 32'd33);

    // Chip disable forces dout to 0 and blocks writes.
    rd(5'd5);
    chk("pre_dis", dout, 32'd5);
    for (int w = 0; w < 2; w++) begin
      for (int a = 8; a <= 12; a++) begin
        op(1'b0, 1'b0, 1'(w), 5'(a), 32'hDEAD_BEEF);
        chk($sformatf("dis_w%0d_a%0d", w, a), dout, 32'h0);
      end
    end
    rd(5'd8);
    chk("en_rd8", dout, 32'd8);
    rd(5'd9);
    chk("en_rd9", dout, xval);
    rd(5'd10);
    chk("en_rd10", dout, 32'h0);
    rd(5'd11);
    chk("en_rd11", dout, 32'd11);
    rd(5'd12);
    chk("en_rd12", dout, 32'd12);

    // Write output and back-to-back access at the top word.
    rd(5'd2);
    wr(5'd31, 32'hA5A5_A5A5);
    chk("wr31_dout", dout, 32'h0);
    rd(5'd31);
    chk("raw_rd31", dout, 32'hA5A5_A5A5);
    rd(5'd0);
    chk("b2b_rd0", dout, 32'h0);
    rd(5'd31);
    chk("b2b_rd31", dout, 32'hA5A5_A5A5);

    // Mid-operation reset discards the write and clears memory.
    rd(5'd7);
    chk("pre_rst", dout, 32'd7);
    op(1'b1, 1'b1, 1'b1, 5'd5, 32'h1234_5678);
    chk("mid_rst_dout", dout, 32'h0);
    rd(5'd5);
    chk("mid_rst_rd5", dout, 32'h0);
    rd(5'd31);
    chk("mid_rst_rd31", dout, 32'h0);
    rd(5'd18);
    chk("mid_rst_rd18", dout, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
